// File: rtl/bitmanip_scheduler.sv
// Bit-manipulation issue scheduler.
// Fast units (simple, shifter, bitcnt, bmat) and illegal ops retire through a
// one-deep fast stage with latency 1. Multi-cycle units (clmul, crc, bextdep)
// are sequenced by an IDLE/BUSY/HOLD FSM with a watchdog. A single writeback
// port is shared, and the fast stage wins over a multi-cycle result.
module bitmanip_scheduler #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [2:0]               issue_unit_i,
  input  logic [8:0]               issue_func_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  output logic                     fast_valid_o,
  output logic [1:0]               fast_unit_o,
  output logic [8:0]               fast_func_o,
  input  logic [XLEN-1:0]          fast_result_i,
  output logic                     mc_start_o,
  output logic [1:0]               mc_unit_o,
  output logic [8:0]               mc_func_o,
  output logic                     mc_abort_o,
  input  logic                     mc_done_i,
  input  logic [XLEN-1:0]          mc_result_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_illegal_o,
  output logic                     timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  // Watchdog: counts BUSY cycles of the current multi-cycle op.
  logic [WD_W-1:0] wdog_q;

  // Fast stage: one registered result, retired on the following cycle.
  logic                     fast_valid_q;
  logic [TRANS_ID_BITS-1:0] fast_tid_q;
  logic [XLEN-1:0]          fast_result_q;
  logic                     fast_illegal_q;

  // Context of the multi-cycle op in flight.
  logic [1:0]               mc_unit_q;
  logic [8:0]               mc_func_q;
  logic [TRANS_ID_BITS-1:0] mc_tid_q;

  // Hold register: a finished multi-cycle result waiting for the port.
  logic                     pend_q;
  logic [TRANS_ID_BITS-1:0] hold_tid_q;
  logic [XLEN-1:0]          hold_result_q;
  logic                     hold_illegal_q;

  logic            is_multi, is_illegal, ready, accept;
  logic            fast_take, fast_fire, mc_fire;
  logic            busy, done_ev, wd_expire, mc_end;
  logic [XLEN-1:0] mc_fixed;

  // Decode the offered op, decide acceptance and detect multi-cycle completion.
  always_comb begin
    is_multi   = issue_unit_i[2] && (issue_unit_i != 3'd7);
    is_illegal = (issue_unit_i == 3'd7);
    busy       = (state_q == BUSY);
    if (is_multi) ready = !flush_i && !rst_i && (state_q == IDLE);
    else          ready = !flush_i && !rst_i && (state_q != HOLD);
    accept     = issue_valid_i && ready;
    fast_take  = accept && !is_multi;           // fast unit or illegal op
    fast_fire  = accept && !issue_unit_i[2];    // only real fast units
    mc_fire    = accept && is_multi;
    done_ev    = busy && mc_done_i && !flush_i; // done beats the watchdog
    wd_expire  = busy && !mc_done_i && !flush_i && (wdog_q == WD_LAST);
    mc_end     = done_ev || wd_expire;
  end

  // Sign-extend the low word for W variants of clmul and bextdep; crc passes through.
  always_comb begin
    mc_fixed = mc_result_i;
    if (mc_func_q[0] && (mc_unit_q != 2'd1)) begin
      for (int i = 32; i < XLEN; i++) mc_fixed[i] = mc_result_i[31];
    end
  end

  // Next-state logic of the multi-cycle FSM.
  always_comb begin
    // NOTE: defaulting state_d before the case keeps this block free of inferred latches.
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (mc_fire) state_d = BUSY;
        // A fast result registered in the same cycle owns the next writeback slot.
        BUSY:    if (mc_end) state_d = fast_take ? HOLD : IDLE;
        HOLD:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Fast stage, multi-cycle context, watchdog and hold register.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      fast_valid_q   <= 1'b0;
      fast_tid_q     <= '0;
      fast_result_q  <= '0;
      fast_illegal_q <= 1'b0;
      mc_unit_q      <= '0;
      mc_func_q      <= '0;
      mc_tid_q       <= '0;
      wdog_q         <= '0;
      pend_q         <= 1'b0;
      hold_tid_q     <= '0;
      hold_result_q  <= '0;
      hold_illegal_q <= 1'b0;
    end else begin
      fast_valid_q <= fast_take;
      if (fast_take) begin
        fast_tid_q     <= issue_trans_id_i;
        fast_result_q  <= is_illegal ? '0 : fast_result_i;
        fast_illegal_q <= is_illegal;
      end

      if (mc_fire) begin
        mc_unit_q <= issue_unit_i[1:0];
        mc_func_q <= issue_func_i;
        mc_tid_q  <= issue_trans_id_i;
        wdog_q    <= '0;
      end else if (busy && !mc_end) begin
        wdog_q <= wdog_q + WD_W'(1);
      end

      if (mc_end) begin
        pend_q         <= 1'b1;
        hold_tid_q     <= mc_tid_q;
        hold_result_q  <= done_ev ? mc_fixed : '0;
        hold_illegal_q <= wd_expire;
      end else if (pend_q && !fast_valid_q) begin
        pend_q <= 1'b0;                          // held result retired this cycle
      end
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    issue_ready_o = ready;
    fast_valid_o  = fast_fire;
    fast_unit_o   = fast_fire ? issue_unit_i[1:0] : 2'd0;
    fast_func_o   = fast_fire ? issue_func_i : 9'd0;
    mc_start_o    = mc_fire;
    mc_unit_o     = 2'd0;
    mc_func_o     = 9'd0;
    if (mc_fire) begin
      mc_unit_o = issue_unit_i[1:0];
      mc_func_o = issue_func_i;
    end else if (busy) begin
      mc_unit_o = mc_unit_q;
      mc_func_o = mc_func_q;
    end
    mc_abort_o    = busy && (flush_i || wd_expire);
    timeout_o     = wd_expire;
    wb_valid_o    = fast_valid_q || pend_q;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_illegal_o  = 1'b0;
    if (fast_valid_q) begin
      wb_trans_id_o = fast_tid_q;
      wb_result_o   = fast_result_q;
      wb_illegal_o  = fast_illegal_q;
    end else if (pend_q) begin
      wb_trans_id_o = hold_tid_q;
      wb_result_o   = hold_result_q;
      wb_illegal_o  = hold_illegal_q;
    end
    if (rst_i) begin
      issue_ready_o = 1'b0;
      fast_valid_o  = 1'b0;
      fast_unit_o   = 2'd0;
      fast_func_o   = 9'd0;
      mc_start_o    = 1'b0;
      mc_unit_o     = 2'd0;
      mc_func_o     = 9'd0;
      mc_abort_o    = 1'b0;
      timeout_o     = 1'b0;
      wb_valid_o    = 1'b0;
      wb_trans_id_o = '0;
      wb_result_o   = '0;
      wb_illegal_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_bitmanip_scheduler.sv
// Self-checking bench for bitmanip_scheduler: directed scenarios followed by
// randomized traffic, all compared against a timestamp-based reference model
// that schedules each expected writeback at the cycle it must appear.
module tb_bitmanip_scheduler;
  localparam int XLEN    = 64;
  localparam int TW      = 3;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_i, flush_i, issue_valid_i, issue_ready_o;
  logic [2:0]      issue_unit_i;
  logic [8:0]      issue_func_i;
  logic [TW-1:0]   issue_trans_id_i;
  logic            fast_valid_o;
  logic [1:0]      fast_unit_o;
  logic [8:0]      fast_func_o;
  logic [XLEN-1:0] fast_result_i;
  logic            mc_start_o;
  logic [1:0]      mc_unit_o;
  logic [8:0]      mc_func_o;
  logic            mc_abort_o, mc_done_i;
  logic [XLEN-1:0] mc_result_i;
  logic            wb_valid_o;
  logic [TW-1:0]   wb_trans_id_o;
  logic [XLEN-1:0] wb_result_o;
  logic            wb_illegal_o, timeout_o;

  always #5 clk = ~clk;

  bitmanip_scheduler #(.XLEN(XLEN), .TRANS_ID_BITS(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_unit_i(issue_unit_i), .issue_func_i(issue_func_i),
    .issue_trans_id_i(issue_trans_id_i),
    .fast_valid_o(fast_valid_o), .fast_unit_o(fast_unit_o),
    .fast_func_o(fast_func_o), .fast_result_i(fast_result_i),
    .mc_start_o(mc_start_o), .mc_unit_o(mc_unit_o), .mc_func_o(mc_func_o),
    .mc_abort_o(mc_abort_o), .mc_done_i(mc_done_i), .mc_result_i(mc_result_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o), .wb_illegal_o(wb_illegal_o),
    .timeout_o(timeout_o)
  );

  typedef struct packed {
    logic [TW-1:0]   tid;
    logic [XLEN-1:0] res;
    logic            ill;
  } wb_t;

  // Reference model: expected writebacks keyed by the cycle they must appear in.
  wb_t         sched [int];
  int          cyc_n = 0;
  bit          mc_active = 1'b0;
  int          mc_start_cyc = 0;
  int          mc_lat = 0;
  int          hold_at = -1;
  logic [2:0]  mc_unit_m = '0;
  logic [8:0]  mc_func_m = '0;
  logic [TW-1:0] mc_tag_m = '0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_n, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input logic rst, input logic flush, input logic v,
                      input logic [2:0] unit, input logic [8:0] func, input logic [TW-1:0] tid,
                      input logic done, input logic [XLEN-1:0] mres, input logic [XLEN-1:0] fres);
    logic is_multi, fast_ok, multi_ok, acc, fast_acc, to, fin;
    int   busy_n, slot;
    wb_t  e;
    logic [XLEN-1:0] r;
    @(negedge clk);
    rst_i = rst; flush_i = flush; issue_valid_i = v; issue_unit_i = unit;
    issue_func_i = func; issue_trans_id_i = tid; mc_done_i = done;
    mc_result_i = mres; fast_result_i = fres;
    #1;
    if (rst) begin
      check("rst_ctrl", XLEN'({issue_ready_o, fast_valid_o, fast_unit_o, fast_func_o, mc_start_o,
                               mc_unit_o, mc_func_o, mc_abort_o, timeout_o, wb_valid_o,
                               wb_trans_id_o, wb_illegal_o}), '0);
      check("rst_wb_result", wb_result_o, '0);
      sched.delete();
      mc_active = 1'b0;
      hold_at = -1;
    end else begin
      is_multi = (unit >= 3'd4) && (unit <= 3'd6);
      fast_ok  = !flush && (cyc_n != hold_at);
      multi_ok = fast_ok && !mc_active;
      acc      = v && (is_multi ? multi_ok : fast_ok);
      fast_acc = acc && !is_multi;
      check("issue_ready", XLEN'(issue_ready_o), XLEN'(is_multi ? multi_ok : fast_ok));
      check("fast_valid", XLEN'(fast_valid_o), XLEN'(acc && unit < 3'd4));
      if (acc && unit < 3'd4) begin
        check("fast_unit", XLEN'(fast_unit_o), XLEN'(unit));
        check("fast_func", XLEN'(fast_func_o), XLEN'(func));
      end
      check("mc_start", XLEN'(mc_start_o), XLEN'(acc && is_multi));
      if (acc && is_multi) begin
        check("mc_unit_start", XLEN'(mc_unit_o), XLEN'(unit - 3'd4));
        check("mc_func_start", XLEN'(mc_func_o), XLEN'(func));
      end

      busy_n = cyc_n - mc_start_cyc;
      to  = mc_active && !flush && !done && (busy_n == TIMEOUT);
      fin = mc_active && !flush && (done || to);
      check("mc_abort", XLEN'(mc_abort_o), XLEN'(mc_active && (flush || to)));
      check("timeout", XLEN'(timeout_o), XLEN'(to));
      if (mc_active) begin
        check("mc_unit_held", XLEN'(mc_unit_o), XLEN'(mc_unit_m - 3'd4));
        check("mc_func_held", XLEN'(mc_func_o), XLEN'(mc_func_m));
      end

      if (sched.exists(cyc_n)) begin
        e = sched[cyc_n];
        sched.delete(cyc_n);
        check("wb_valid", XLEN'(wb_valid_o), XLEN'(1));
        check("wb_tid", XLEN'(wb_trans_id_o), XLEN'(e.tid));
        check("wb_result", wb_result_o, e.res);
        check("wb_illegal", XLEN'(wb_illegal_o), XLEN'(e.ill));
      end else begin
        check("wb_idle", XLEN'(wb_valid_o), XLEN'(0));
      end

      if (flush) begin
        sched.delete();
        mc_active = 1'b0;
        hold_at = -1;
      end else begin
        if (fast_acc)
          sched[cyc_n + 1] = '{tid, (unit == 3'd7) ? '0 : fres, unit == 3'd7};
        if (fin) begin
          if (to) r = '0;
          else if (mc_func_m[0] && mc_unit_m != 3'd5) r = {{32{mres[31]}}, mres[31:0]};
          else r = mres;
          slot = fast_acc ? cyc_n + 2 : cyc_n + 1;
          if (fast_acc) hold_at = cyc_n + 1;
          sched[slot] = '{mc_tag_m, r, to};
          mc_active = 1'b0;
        end
        if (acc && is_multi) begin
          mc_active = 1'b1;
          mc_start_cyc = cyc_n;
          mc_unit_m = unit;
          mc_func_m = func;
          mc_tag_m = tid;
          case ($urandom_range(0, 19))
            0:       mc_lat = TIMEOUT + 5;
            1:       mc_lat = TIMEOUT;
            default: mc_lat = $urandom_range(1, 12);
          endcase
        end
      end
    end
    cyc_n++;
  endtask

  task automatic nop(input logic done = 1'b0, input logic [XLEN-1:0] mres = '0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, '0, done, mres, '0);
  endtask

  task automatic op(input logic [2:0] unit, input logic [8:0] func, input logic [TW-1:0] tid,
                    input logic [XLEN-1:0] fres);
    step(1'b0, 1'b0, 1'b1, unit, func, tid, 1'b0, '0, fres);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; issue_unit_i = '0;
    issue_func_i = '0; issue_trans_id_i = '0; mc_done_i = 1'b0;
    mc_result_i = '0; fast_result_i = '0;

    // Reset with an op offered: nothing accepted, all outputs low.
    step(1'b1, 1'b0, 1'b1, 3'd4, 9'd1, 3'd1, 1'b1, 64'hFF, 64'hFF);
    step(1'b1, 1'b0, 1'b1, 3'd0, 9'd1, 3'd1, 1'b0, '0, 64'hFF);

    // Fast op unit 1, tag 2, result 0x55.
    op(3'd1, 9'h010, 3'd2, 64'h55);
    nop();

    // Illegal op, tag 3.
    op(3'd7, 9'h000, 3'd3, 64'hDEAD);
    nop();

    // CLMULW, tag 5, done 8 cycles after start; then a multi op must be accepted again.
    op(3'd4, 9'h003, 3'd5, '0);
    repeat (7) nop();
    nop(1'b1, 64'h0000_0000_8000_0001);
    nop();
    step(1'b0, 1'b0, 1'b0, 3'd4, 9'd0, '0, 1'b0, '0, '0);

    // Done coincides with fast op tag 1: fast first, multi next, fast blocked in between.
    op(3'd5, 9'h000, 3'd6, '0);
    repeat (3) nop();
    step(1'b0, 1'b0, 1'b1, 3'd0, 9'h020, 3'd1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hAA);
    op(3'd0, 9'h020, 3'd4, 64'hBB);
    nop();
    nop();

    // Crc with no done: watchdog abort, illegal retire, then a new multi op.
    op(3'd5, 9'h001, 3'd4, '0);
    repeat (TIMEOUT + 1) nop();
    op(3'd6, 9'h001, 3'd2, '0);
    nop(1'b1, 64'hCAFE_0000_FFFF_FFFF);
    nop();

    // Flush while BUSY with the fast stage valid; a late done is ignored.
    op(3'd6, 9'h000, 3'd7, '0);
    nop();
    op(3'd2, 9'h000, 3'd2, 64'h77);
    step(1'b0, 1'b1, 1'b0, 3'd0, 9'd0, '0, 1'b0, '0, '0);
    nop(1'b1, 64'h99);
    nop();

    // Flush while HOLD drops the held result.
    op(3'd4, 9'h000, 3'd1, '0);
    nop();
    step(1'b0, 1'b0, 1'b1, 3'd3, 9'h000, 3'd6, 1'b1, 64'h5, 64'h6);
    step(1'b0, 1'b1, 1'b0, 3'd0, 9'd0, '0, 1'b0, '0, '0);
    nop();

    // Reset while BUSY: no abort, no writeback.
    op(3'd4, 9'h000, 3'd3, '0);
    nop();
    step(1'b1, 1'b0, 1'b0, 3'd0, 9'd0, '0, 1'b0, '0, '0);
    nop();
    nop();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic d;
      d = 1'b0;
      if (mc_active && (cyc_n - mc_start_cyc) == mc_lat) d = 1'b1;
      else if (!mc_active && $urandom_range(0, 15) == 0) d = 1'b1;
      step(1'b0, $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), 9'($urandom), TW'($urandom), d,
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    nop();
    nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitmanip_scheduler.md
BITMANIP_SCHEDULER -- requirements
Module: bitmanip_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/result width.
REQ-002 SHALL have parameter TRANS_ID_BITS, default 3, width of the transaction tag.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum number of BUSY cycles before a multi-cycle op is aborted.
REQ-004 SHALL have ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  kill all in-flight work.
- issue_valid_i  in  1  op offered.
- issue_ready_o  out  1  op accepted when valid&ready.
- issue_unit_i  in  3  0 simple, 1 shifter, 2 bitcnt, 3 bmat (fast); 4 clmul, 5 crc, 6 bextdep (multi); 7 illegal.
- issue_func_i  in  9  BM_FUNC code; bit0 = W variant.
- issue_trans_id_i  in  TRANS_ID_BITS  tag.
- fast_valid_o  out  1  fast unit select strobe.
- fast_unit_o  out  2  fast unit index.
- fast_func_o  out  9  func to fast unit.
- fast_result_i  in  XLEN  combinational fast unit result, same cycle.
- mc_start_o  out  1  one-cycle start pulse to multi-cycle unit.
- mc_unit_o  out  2  0 clmul, 1 crc, 2 bextdep.
- mc_func_o  out  9  func, held stable while BUSY.
- mc_abort_o  out  1  one-cycle abort pulse.
- mc_done_i  in  1  multi-cycle result valid (one-cycle pulse).
- mc_result_i  in  XLEN  multi-cycle result.
- wb_valid_o  out  1  result writeback strobe; no backpressure.
- wb_trans_id_o  out  TRANS_ID_BITS  tag of retiring op.
- wb_result_o  out  XLEN  result.
- wb_illegal_o  out  1  retiring op was illegal.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Function
REQ-005 SHALL implement FSM IDLE, BUSY, HOLD for the multi-cycle path.
REQ-006 SHALL assert issue_ready_o = !flush_i & !rst_i & (fast/illegal op: state != HOLD; multi op: state == IDLE).
REQ-007 On accepted fast op, SHALL drive fast_valid_o=1, fast_unit_o=issue_unit_i[1:0], fast_func_o=issue_func_i combinationally, and register fast_result_i plus tag into the fast stage; SHALL writeback from the fast stage on the next cycle (latency 1).
REQ-008 On accepted illegal op (unit 7), SHALL load the fast stage with result 0 and illegal flag; SHALL retire it next cycle with wb_illegal_o=1.
REQ-009 On accepted multi op in IDLE, SHALL pulse mc_start_o that cycle, latch unit, func, tag, go BUSY, and clear the watchdog counter.
REQ-010 In BUSY, SHALL increment the watchdog each cycle; mc_done_i SHALL take priority over the watchdog in the same cycle.
REQ-011 On mc_done_i in BUSY with fast stage empty next cycle, SHALL writeback the multi result in the cycle after done and return to IDLE.
REQ-012 On mc_done_i in BUSY coinciding with a fast result being registered, SHALL capture the multi result in the hold register, go HOLD, let the fast result retire first, then retire the held result the following cycle and return to IDLE.
REQ-013 At most one wb_valid_o per cycle; fast stage SHALL win over a multi result.
REQ-014 For clmul and bextdep with func[0]=1, SHALL set wb_result_o = sign-extension of mc_result_i[31:0]; crc results SHALL pass unmodified.
REQ-015 When the watchdog reaches TIMEOUT-1 in BUSY without done, SHALL pulse mc_abort_o and timeout_o, retire the op with wb_illegal_o=1 and result 0 next cycle, and go IDLE.
REQ-016 mc_done_i outside BUSY SHALL be ignored.
REQ-017 flush_i SHALL clear fast stage and hold register, suppress wb_valid_o from the next cycle on, pulse mc_abort_o if BUSY, and go IDLE.
REQ-018 Fast ops SHALL be accepted while BUSY; wb_trans_id_o order follows completion, not issue.

Reset
REQ-019 On rst_i, SHALL go IDLE, clear watchdog, fast stage and hold register; all outputs SHALL be 0 during reset, including mc_abort_o and issue_ready_o.
REQ-020 Reset asserted while BUSY SHALL NOT produce mc_abort_o or wb_valid_o.

Verification
REQ-021 Fast op unit 1, tag 2, fast_result_i=0x55 -> next cycle wb_valid_o=1, tag 2, result 0x55.
REQ-022 Clmul func CLMULW tag 5; mc_done_i after 8 cycles with result 0x0000_0000_8000_0001 -> wb_result_o=0xFFFF_FFFF_8000_0001, tag 5, state IDLE.
REQ-023 mc_done_i with fast op tag 1 in same cycle -> fast tag 1 retires at T+1, multi tag at T+2, issue_ready_o=0 for fast op at T+1.
REQ-024 Crc op, no done for 64 cycles -> mc_abort_o and timeout_o pulse once, wb_illegal_o=1 next cycle, second multi op then accepted.
REQ-025 Flush while BUSY with fast stage valid -> mc_abort_o pulse, no wb_valid_o next cycle, late mc_done_i ignored.
REQ-026 Illegal unit 7, tag 3 -> wb_valid_o=1, wb_illegal_o=1, result 0 next cycle.
